banked_sync_ram: RTL and testbench
==================================

# banked_sync_ram

Parametrised, banked, single-port synchronous RAM with a valid/ready request interface, per-byte write enables and a registered read path. The memory is split into NUM_BANKS banks. Upper address bits select the bank and lower bits index within it. After every reset it clears all contents to zero. It is the next-generation main memory for the processor data path and replaces the fixed four-bank, tristate-bus RAM with separate read and write buses.

## Interface
- ADDR_WIDTH, 12: word address width; the bank is selected by the top log2(NUM_BANKS) bits.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- NUM_BANKS, 4: bank count; must be a power of 2 and at least 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte enables, one per byte lane; bit i covers data[8i+7:8i].
- err_inject  in  1  on a write, corrupt the stored parity of lane 0; ignored without parity.
- rvalid  out  1  read response valid, single-cycle pulse.
- rdata  out  DATA_WIDTH  read data; held until the next read response.
- rerr  out  1  parity error on this response; qualified by rvalid.
- init_done  out  1  clear sweep finished.

## Operation
- Terms:
  - BANK_BITS = log2(NUM_BANKS).
  - DEPTH = 2^(ADDR_WIDTH-BANK_BITS) words per bank.
  - LANES = DATA_WIDTH/8.
  - bank = req_addr[ADDR_WIDTH-1 -: BANK_BITS].
  - index = req_addr[ADDR_WIDTH-BANK_BITS-1:0].
- The FSM has two states, INIT and RUN.
- INIT:
  - Entered on reset.
  - A sweep counter runs from 0 to DEPTH-1, writing zero (and correct parity) to that index in every bank simultaneously, one index per cycle.
  - req_ready is 0 throughout INIT.
  - When the counter reaches DEPTH-1 and that write completes, the FSM moves to RUN and init_done is set.
- RUN:
  - req_ready is 1 every cycle.
  - A request is accepted when req_valid && req_ready.
  - Only the addressed bank is enabled; the other banks hold their contents.
- Write: each lane with req_be[i]=1 is written and the other lanes keep their contents. req_be of all zeros is accepted and is a no-op. A write produces no response.
- Read:
  - The selected bank's word is registered into rdata.
  - rvalid is 1 for exactly one cycle.
  - Unaccepted cycles do not change rdata.
- A write followed by a read of the same address in the next cycle returns the new data. The write completes at the accepting edge, so no bypass is needed.
- Reset asserted mid-sweep or mid-operation:
  - Aborts immediately.
  - Outputs return to their reset values.
  - The sweep restarts from index 0 after rst falls.
  - An in-flight read response is dropped.

## Timing
- Reset values:
  - req_ready=0, rvalid=0, rdata=0, rerr=0, init_done=0.
  - FSM=INIT, sweep counter=0.
- INIT lasts exactly DEPTH cycles after rst deasserts; req_ready rises on cycle DEPTH. With the defaults this is 1024 cycles.
- Read latency:
  - A read accepted at edge N has rvalid/rdata/rerr valid after edge N+1.
  - Back-to-back reads sustain one response per cycle.
- There is no backpressure on responses; the consumer must take rvalid when it is pulsed.
- init_done stays 1 until the next reset.

## Configuration
- BANKED_RAM_PARITY_EN defined:
  - Each bank stores one even-parity bit per byte lane, written together with the lane.
  - With err_inject=1 on a write, the inverted parity bit is stored for lane 0 (only if req_be[0]=1).
  - On a read, rerr=1 if any lane's recomputed parity mismatches.
- Not defined:
  - No parity storage.
  - err_inject is ignored and rerr is tied to 0.

## Structure
- Package banked_ram_pkg holds:
  - The FSM state enum (INIT, RUN).
  - A function computing BANK_BITS from NUM_BANKS.
  - A LANES constant function.
  - A parity helper function.
- Sub-module ram_bank:
  - A synchronous RAM of one bank, DEPTH x DATA_WIDTH, with per-lane write enables and an optional parity array under the macro.
  - Instantiated NUM_BANKS times in a generate loop.
- The top level contains the FSM, the sweep counter, the bank decode, the read mux and the response registers.

## Test plan
All scenarios use the defaults (12-bit address, 32-bit data, 4 banks, DEPTH=1024).
- Reset, then poll -> req_ready=0 for exactly 1024 cycles, then 1; init_done=1; a read of 0x000 returns 0x00000000.
- Write 0xDEADBEEF with be=4'hF to 0xC05, then read 0xC05 in the next cycle -> rvalid one cycle later with rdata=0xDEADBEEF. A read of 0x005 (same index, bank 0) returns 0.
- Write 0x11223344 with be=4'hF, then 0xAABBCCDD with be=4'b0101, both to 0x123 -> a read returns 0x11BB33DD.
- Assert rst at sweep index 500 -> all outputs at reset values. After release, req_ready stays 0 for a full 1024 cycles; address 0x3FF reads 0.
- Issue 8 back-to-back reads of 0x400-0x407 after writing value = address -> rvalid is high for 8 consecutive cycles and data appears in order.
- With BANKED_RAM_PARITY_EN: write 0x0 with err_inject=1 to 0x010, then read it -> rerr=1. Read 0x011 -> rerr=0. Without the macro, both reads give rerr=0.

Source files
------------

// File: rtl/banked_ram_pkg.sv
// Shared types and helpers for banked_sync_ram: FSM states, geometry and parity functions.
package banked_ram_pkg;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    function automatic int bank_bits(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int lanes(input int data_width);
        return data_width / 8;
    endfunction

    // Even parity: the stored bit makes the 9-bit group have an even number of ones.
    function automatic logic parity8(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/banked_sync_ram_bank.sv
// One bank of banked_sync_ram: DEPTH x DATA_WIDTH synchronous RAM with per-lane writes.
// Parity storage is present only when BANKED_RAM_PARITY_EN is defined.
module ram_bank
    import banked_ram_pkg::*;
#(
    parameter int IDX_W      = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            en,
    input  logic                            we,
    input  logic [lanes(DATA_WIDTH)-1:0]    be,
    input  logic [IDX_W-1:0]                index,
    input  logic [DATA_WIDTH-1:0]           wdata,
    output logic [DATA_WIDTH-1:0]           rdata
`ifdef BANKED_RAM_PARITY_EN
    ,
    input  logic [lanes(DATA_WIDTH)-1:0]    wpar,
    output logic [lanes(DATA_WIDTH)-1:0]    rpar
`endif
);
    localparam int LANES = lanes(DATA_WIDTH);
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end else begin
                rdata <= mem[index];
            end
        end
    end

`ifdef BANKED_RAM_PARITY_EN
    logic [LANES-1:0] par [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) par[index][i] <= wpar[i];
                end
            end else begin
                rpar <= par[index];
            end
        end
    end
`endif

endmodule

// File: rtl/banked_sync_ram.sv
// Banked single-port RAM with valid/ready requests, byte enables and a two-stage read path.
// Clears itself after reset; optional lane parity under BANKED_RAM_PARITY_EN.
module banked_sync_ram
    import banked_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]        req_wdata,
    input  logic [DATA_WIDTH/8-1:0]      req_be,
    input  logic                         err_inject,
    output logic                         rvalid,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         rerr,
    output logic                         init_done
);
    localparam int BANK_BITS = bank_bits(NUM_BANKS);
    localparam int IDX_W     = ADDR_WIDTH - BANK_BITS;
    localparam int LANES     = lanes(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t                 state, state_nxt;
    logic                   sweeping;
    logic [IDX_W-1:0]       sweep;
    logic                   accept, rd_acc;
    logic [BANK_BITS-1:0]   bank_sel, bank_q;
    logic [1:0]             vld_pipe;
    logic                   par_err;

    logic                   b_we;
    logic [LANES-1:0]       b_be;
    logic [IDX_W-1:0]       b_idx;
    logic [DATA_WIDTH-1:0]  b_wdata;
    logic [NUM_BANKS-1:0]   b_en;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] b_rdata;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (state == INIT && sweep == LAST_IDX) state_nxt = RUN;
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state == RUN);
        init_done = (state == RUN);
        sweeping  = (state == INIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sweep <= '0;
        else if (sweeping) sweep <= sweep + 1'b1;
    end

    assign bank_sel = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign accept   = req_valid && req_ready;
    assign rd_acc   = accept && !req_we;

    // During the sweep every bank writes zero at the same index.
    assign b_we    = sweeping ? 1'b1 : req_we;
    assign b_be    = sweeping ? '1 : req_be;
    assign b_idx   = sweeping ? sweep : req_addr[IDX_W-1:0];
    assign b_wdata = sweeping ? '0 : req_wdata;

`ifdef BANKED_RAM_PARITY_EN
    logic [LANES-1:0] b_wpar;
    logic [NUM_BANKS-1:0][LANES-1:0] b_rpar;

    always_comb begin
        b_wpar = '0;
        if (!sweeping) begin
            for (int i = 0; i < LANES; i++)
                b_wpar[i] = parity8(req_wdata[i*8 +: 8]);
            b_wpar[0] = b_wpar[0] ^ err_inject;
        end
    end

    always_comb begin
        par_err = 1'b0;
        for (int i = 0; i < LANES; i++)
            if (parity8(b_rdata[bank_q][i*8 +: 8]) != b_rpar[bank_q][i]) par_err = 1'b1;
    end
`else
    logic unused_err_inject;
    assign unused_err_inject = err_inject;
    assign par_err = 1'b0;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign b_en[b] = sweeping || (accept && bank_sel == BANK_BITS'(b));

        ram_bank #(
            .IDX_W      (IDX_W),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk   (clk),
            .en    (b_en[b]),
            .we    (b_we),
            .be    (b_be),
            .index (b_idx),
            .wdata (b_wdata),
            .rdata (b_rdata[b])
`ifdef BANKED_RAM_PARITY_EN
            ,
            .wpar  (b_wpar),
            .rpar  (b_rpar[b])
`endif
        );
    end

    // Stage 1 is the bank's own read register; stage 2 muxes it into the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            bank_q   <= '0;
            rdata    <= '0;
            rerr     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], rd_acc};
            if (rd_acc) bank_q <= bank_sel;
            if (vld_pipe[0]) begin
                rdata <= b_rdata[bank_q];
                rerr  <= par_err;
            end
        end
    end

    assign rvalid = vld_pipe[1];

endmodule

// File: tb/tb_banked_sync_ram.sv
// Randomised self-checking bench for banked_sync_ram against an address-level memory model.
module tb_banked_sync_ram;
    localparam int AW = 12, DW = 32, NB = 4, DEPTH = 1024;
`ifdef BANKED_RAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, err_inject = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0] req_be = '0;
    logic req_ready, rvalid, rerr, init_done;
    logic [DW-1:0] rdata;

    banked_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .err_inject(err_inject), .rvalid(rvalid), .rdata(rdata), .rerr(rerr),
        .init_done(init_done));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a flat word array, a bad-parity flag per address, and a
    // queue of pending responses tagged with the cycle they must appear in.
    typedef struct { logic [31:0] d; logic e; longint due; } resp_t;
    logic [31:0] mem [1 << AW];
    logic        bad [1 << AW];
    resp_t       rq[$];
    longint      cyc = 0;
    int          init_cnt = 0;
    logic        ready_m = 1'b0, exp_rvalid = 1'b0, exp_rerr = 1'b0;
    logic [31:0] exp_rdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt = 0; ready_m = 1'b0; rq.delete();
            exp_rvalid = 1'b0; exp_rdata = '0; exp_rerr = 1'b0;
            for (int a = 0; a < (1 << AW); a++) begin mem[a] = '0; bad[a] = 1'b0; end
        end else begin
            cyc++;
            exp_rvalid = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                exp_rvalid = 1'b1; exp_rdata = rq[0].d; exp_rerr = rq[0].e;
                void'(rq.pop_front());
            end
            if (!ready_m) begin
                init_cnt++;
                if (init_cnt == DEPTH) ready_m = 1'b1;
            end else if (req_valid) begin
                if (req_we) begin
                    for (int i = 0; i < 4; i++)
                        if (req_be[i]) mem[req_addr][i*8 +: 8] = req_wdata[i*8 +: 8];
                    if (req_be[0]) bad[req_addr] = err_inject;
                end else begin
                    resp_t r;
                    r.d = mem[req_addr]; r.e = PAR & bad[req_addr]; r.due = cyc + 1;
                    rq.push_back(r);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", req_ready, ready_m);
        chk("init_done", init_done, ready_m);
        chk("rvalid", rvalid, exp_rvalid);
        chk("rdata", rdata, exp_rdata);
        if (exp_rvalid) chk("rerr", rerr, exp_rerr);
    end

    task automatic drive(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic inj);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be; err_inject = inj;
        @(posedge clk); #1;
        req_valid = 1'b0; err_inject = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic e);
        int n;
        drive(1'b0, a, '0, '0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 4) begin n++; @(negedge clk); end
        chk({name, "_valid"}, rvalid, 1);
        chk({name, "_data"}, rdata, d);
        chk({name, "_err"}, rerr, e);
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 2000) begin n++; @(negedge clk); end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string name);
        @(negedge clk);
        chk({name, "_ready"}, req_ready, 0);
        chk({name, "_rvalid"}, rvalid, 0);
        chk({name, "_rdata"}, rdata, 0);
        chk({name, "_rerr"}, rerr, 0);
        chk({name, "_init"}, init_done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst0");
        rst = 1'b0;
        wait_ready(n);
        chk("init_len", n, DEPTH);
        rd_chk("rd_zero", 12'h000, 32'h0, 1'b0);

        drive(1'b1, 12'hC05, 32'hDEADBEEF, 4'hF, 1'b0);
        rd_chk("raw", 12'hC05, 32'hDEADBEEF, 1'b0);
        rd_chk("other_bank", 12'h005, 32'h0, 1'b0);

        drive(1'b1, 12'h123, 32'h11223344, 4'hF, 1'b0);
        drive(1'b1, 12'h123, 32'hAABBCCDD, 4'b0101, 1'b0);
        rd_chk("byte_en", 12'h123, 32'h11BB33DD, 1'b0);
        drive(1'b1, 12'h123, 32'hFFFFFFFF, 4'h0, 1'b0);
        rd_chk("be_zero", 12'h123, 32'h11BB33DD, 1'b0);

        for (int k = 0; k < 8; k++) drive(1'b1, AW'(12'h400 + k), 32'h400 + k, 4'hF, 1'b0);
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(12'h400 + k);
                    @(posedge clk); #1;
                end
                req_valid = 1'b0;
            end
            begin
                int m;
                m = 0;
                @(negedge clk);
                while (!rvalid && m < 10) begin m++; @(negedge clk); end
                for (int k = 0; k < 8; k++) begin
                    chk("b2b_valid", rvalid, 1);
                    chk("b2b_data", rdata, 32'h400 + k);
                    @(negedge clk);
                end
                chk("b2b_end", rvalid, 0);
            end
        join
        @(posedge clk); #1;

        drive(1'b1, 12'h010, 32'h0, 4'hF, 1'b1);
        drive(1'b1, 12'h011, 32'h0, 4'hF, 1'b0);
        rd_chk("par_bad", 12'h010, 32'h0, PAR);
        rd_chk("par_ok", 12'h011, 32'h0, 1'b0);

        for (int t = 0; t < 3000; t++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we = $urandom_range(0, 1);
            req_addr = ($urandom_range(0, 7) == 0) ? AW'(12'h3FF)
                     : AW'(($urandom_range(0, 3) << 10) | $urandom_range(0, 15));
            req_wdata = $urandom;
            req_be = 4'($urandom_range(0, 15));
            err_inject = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0; err_inject = 1'b0;

        drive(1'b1, 12'h3FF, 32'h12345678, 4'hF, 1'b0);
        rd_chk("pre_rst", 12'h3FF, 32'h12345678, 1'b0);
        drive(1'b0, 12'h3FF, '0, '0, 1'b0);
        rst = 1'b1;
        chk_reset_vals("rst_run");
        rst = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_reset_vals("rst_mid");
        rst = 1'b0;
        wait_ready(n);
        chk("reinit_len", n, DEPTH);
        rd_chk("cleared", 12'h3FF, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
